uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   UART 8N1 serialiser: transmit side of the UART link used by the ALU top.
//   Takes one byte per accepted start request and drives it on tx_serial as
//   start bit, DATA_BITS data bits (LSB first) and STOP_BITS stop bits, at BAUD_RATE.
//   Sits between the result/response logic and the tx_serial pad.
//   It is the counterpart of the bench's uart_write_byte bit timing.
// PARAMETERS
//   CLK_FREQ   100_000_000  system clock frequency, Hz
//   BAUD_RATE  9600         line rate, bit/s
//   DATA_BITS  8            data bits per frame (5..8)
//   STOP_BITS  1            stop bits per frame (1 or 2)
//   Derived: CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division; 10416 at defaults).
//   CLKS_PER_BIT must be >= 2. Counter width is $clog2(CLKS_PER_BIT).
// PORTS
//   clk           in   1          system clock, rising edge
//   reset         in   1          asynchronous, active-high reset
//   tx_start      in   1          request to send tx_data; sampled only when tx_busy=0
//   tx_data       in   DATA_BITS  byte to send; captured on the accepting edge
//   tx_serial     out  1          serial line, idle high, registered
//   tx_busy       out  1          1 while a frame is in progress
//   tx_done_tick  out  1          one-cycle pulse after the last stop-bit cycle
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE, tx_serial=1, tx_busy=0, tx_done_tick=0.
//     The bit counter, bit index and shift register are cleared.
//   - Reset mid-frame: the line returns high at once, the frame is abandoned
//     and no tx_done_tick is produced.
//   - FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
//   - IDLE: tx_serial=1 and tx_busy=0.
//     On an edge with tx_start=1, load shift_reg<=tx_data, clear the counter and go to START.
//     From the next cycle, tx_serial=0 and tx_busy=1 (1-cycle latency).
//   - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
//   - DATA: tx_serial=shift_reg[0] for CLKS_PER_BIT cycles per bit, then shift right.
//     After DATA_BITS bits, go to STOP.
//   - STOP: tx_serial=1 for STOP_BITS*CLKS_PER_BIT cycles.
//     On the final counter edge, go to IDLE, set tx_busy<=0 and tx_done_tick<=1.
//   - tx_done_tick is high for exactly one cycle, the first IDLE cycle.
//   - Frame length on the line: (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles.
//     At defaults this is 104160 cycles, i.e. 1.0416 ms at 100 MHz.
//   - tx_start while tx_busy=1 is ignored; there is no queueing and no frame corruption.
//     tx_data changes during a frame have no effect.
//   - tx_start in the tx_done_tick cycle is accepted (tx_busy=0).
//     Minimum inter-frame idle is therefore exactly one clock of line high.
//   - tx_start held high continuously gives back-to-back frames, each separated by one idle clock.
//   - The bit counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
//     The bit index never exceeds DATA_BITS-1.
// TESTING (bench with CLK_FREQ=16, BAUD_RATE=1 -> 16 clk/bit, plus one default-param run)
//   1. Send tx_data=0x03 with a 1-cycle tx_start.
//      -> Sampled mid-bit, line = 0,1,1,0,0,0,0,0,0,1.
//      -> tx_busy is high for 160 cycles, then tx_done_tick pulses once.
//   2. Send 0xA5 at default params.
//      -> The bench-style receiver (104166 ns/bit, sampled mid-bit) decodes 0xA5.
//      -> Frame length is 104160 clk.
//   3. Send 0xFF, then pulse tx_start with tx_data=0x00 at cycle 40.
//      -> Only 0xFF is sent; tx_data is not re-latched; a single tx_done_tick.
//   4. Hold tx_start=1 with 0x55, then 0xAA.
//      -> Two frames with exactly one idle-high clock between the stop bit and the next start bit.
//   5. Assert reset at cycle 70 of a 0x3C frame.
//      -> tx_serial=1 and tx_busy=0 immediately, with no tx_done_tick.
//      -> The next tx_start sends a full, correct frame.
//   6. Run with STOP_BITS=2 and send 0x00.
//      -> The stop phase lasts 32 cycles; tx_done_tick comes 176 cycles after acceptance.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: UART transmit serialiser.
// Sends one frame per accepted tx_start: a low start bit, DATA_BITS data bits
// LSB first, then STOP_BITS high stop bits, each bit CLKS_PER_BIT clocks long.
// All outputs come straight from flops, so the pad sees no combinational glitches.
module uart_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done_tick
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 serial_q, serial_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    // Next-state logic: the bit index is reused to count stop bits, since the
    // stop phase never needs more than two bit periods.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        bit_end  = (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                if (tx_start) begin
                    state_d  = START;
                    cnt_d    = '0;
                    idx_d    = '0;
                    shift_d  = tx_data;
                    serial_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d  = DATA;
                    cnt_d    = '0;
                    idx_d    = '0;
                    serial_d = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == DATA_LAST) begin
                        state_d  = STOP;
                        idx_d    = '0;
                        serial_d = 1'b1;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        shift_d  = shift_q >> 1;
                        serial_d = shift_d[0];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any frame and forces the line idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx_serial    = serial_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx.
// Three instances: 16 clk/bit with one stop bit, 16 clk/bit with two stop bits,
// and 100 kHz / 9600 baud (10 clk/bit after integer division).
// A line monitor decodes every frame mid-bit and compares it with the byte
// queued when the request was driven.
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic [2:0] start_v;
    logic [2:0] ser_w;
    logic [2:0] busy_w;
    logic [2:0] done_w;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [7:0] exp_q[$];

    int cpb_tab[3]   = '{16, 16, 10};
    int nbits_tab[3] = '{10, 11, 10};

    int          mon_cnt[3];
    bit          mon_act[3];
    logic [10:0] mon_bits[3];
    logic        mon_prev[3];
    int          done_cnt[3];

    uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .tx_start(start_v[0]), .tx_data(tx_data),
        .tx_serial(ser_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0])
    );

    uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .tx_start(start_v[1]), .tx_data(tx_data),
        .tx_serial(ser_w[1]), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1])
    );

    uart_tx #(.CLK_FREQ(100_000), .BAUD_RATE(9600), .DATA_BITS(8), .STOP_BITS(1)) dut2 (
        .clk(clk), .reset(reset), .tx_start(start_v[2]), .tx_data(tx_data),
        .tx_serial(ser_w[2]), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [7:0] data);
        @(negedge clk);
        tx_data    = data;
        start_v[d] = 1'b1;
        exp_q.push_back(data);
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    // Counts busy cycles (and busy cycles with the line high) until busy drops.
    task automatic waitIdle(input int d, output int busy_cycles, output int high_cycles);
        busy_cycles = 0;
        high_cycles = 0;
        while (busy_w[d] && busy_cycles < 2000) begin
            busy_cycles++;
            if (ser_w[d]) high_cycles++;
            @(negedge clk);
        end
        if (busy_cycles >= 2000) checkOutput("idle_timeout", 32'(busy_cycles), 0);
    endtask

    task automatic finishFrame(input int d);
        int stop_ok;
        logic [7:0] exp_byte;
        stop_ok = 1;
        for (int j = 9; j < nbits_tab[d]; j++) if (mon_bits[d][j] !== 1'b1) stop_ok = 0;
        checkOutput("start_bit", 32'(mon_bits[d][0]), 0);
        checkOutput("stop_bits", 32'(stop_ok), 1);
        if (exp_q.size() == 0) begin
            checkOutput("unexpected_frame", 32'(mon_bits[d][8:1]), 32'hFFFF_FFFF);
        end else begin
            exp_byte = exp_q.pop_front();
            checkOutput("frame_data", 32'(mon_bits[d][8:1]), 32'(exp_byte));
        end
    endtask

    // Line monitor: finds each falling start edge and samples every bit mid-period.
    initial begin
        int k;
        for (int d = 0; d < 3; d++) begin
            mon_act[d]  = 1'b0;
            mon_cnt[d]  = 0;
            mon_bits[d] = '0;
            mon_prev[d] = 1'b1;
            done_cnt[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (reset) begin
                    mon_act[d] = 1'b0;
                end else if (!mon_act[d]) begin
                    if (mon_prev[d] && !ser_w[d]) begin
                        mon_act[d]  = 1'b1;
                        mon_cnt[d]  = 0;
                        mon_bits[d] = '0;
                    end
                end else begin
                    mon_cnt[d]++;
                    if (mon_cnt[d] % cpb_tab[d] == cpb_tab[d] / 2) begin
                        k = mon_cnt[d] / cpb_tab[d];
                        mon_bits[d][k] = ser_w[d];
                        if (k == nbits_tab[d] - 1) begin
                            mon_act[d] = 1'b0;
                            finishFrame(d);
                        end
                    end
                end
                if (!reset && done_w[d]) done_cnt[d]++;
                mon_prev[d] = ser_w[d];
            end
        end
    end

    // Watchdog so the run always ends even if the DUT never goes idle.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence of frames.
    initial begin
        int b;
        int h;
        int dc;
        reset   = 1'b1;
        tx_data = 8'h00;
        start_v = 3'b000;
        repeat (3) @(negedge clk);
        checkOutput("reset_serial", 32'(ser_w), 32'h7);
        checkOutput("reset_busy", 32'(busy_w), 0);
        checkOutput("reset_done", 32'(done_w), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] frame 0x03, 16 clk/bit");
        dc = done_cnt[0];
        applyStimulus(0, 8'h03);
        checkOutput("accept_line_low", 32'(ser_w[0]), 0);
        waitIdle(0, b, h);
        checkOutput("busy_len_03", 32'(b), 160);
        checkOutput("done_tick_03", 32'(done_w[0]), 1);
        @(negedge clk);
        checkOutput("done_width_03", 32'(done_w[0]), 0);
        checkOutput("done_count_03", 32'(done_cnt[0] - dc), 1);

        $display("[TB] frame 0xFF with ignored request at cycle 40");
        dc = done_cnt[0];
        applyStimulus(0, 8'hFF);
        repeat (39) @(negedge clk);
        tx_data    = 8'h00;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        waitIdle(0, b, h);
        checkOutput("busy_rest_ff", 32'(b), 120);
        repeat (20) @(negedge clk);
        checkOutput("no_requeue_busy", 32'(busy_w[0]), 0);
        checkOutput("done_count_ff", 32'(done_cnt[0] - dc), 1);

        $display("[TB] back-to-back 0x55 then 0xAA");
        @(negedge clk);
        tx_data    = 8'h55;
        start_v[0] = 1'b1;
        exp_q.push_back(8'h55);
        @(negedge clk);
        tx_data = 8'hAA;
        exp_q.push_back(8'hAA);
        waitIdle(0, b, h);
        checkOutput("b2b_len_first", 32'(b), 160);
        checkOutput("b2b_gap_line", 32'(ser_w[0]), 1);
        checkOutput("b2b_gap_done", 32'(done_w[0]), 1);
        @(negedge clk);
        checkOutput("b2b_restart_line", 32'(ser_w[0]), 0);
        checkOutput("b2b_restart_busy", 32'(busy_w[0]), 1);
        start_v[0] = 1'b0;
        waitIdle(0, b, h);
        checkOutput("b2b_len_second", 32'(b), 160);
        repeat (4) @(negedge clk);

        $display("[TB] reset in the middle of a 0x3C frame");
        applyStimulus(0, 8'h3C);
        repeat (70) @(negedge clk);
        dc    = done_cnt[0];
        reset = 1'b1;
        #1;
        checkOutput("midreset_serial", 32'(ser_w[0]), 1);
        checkOutput("midreset_busy", 32'(busy_w[0]), 0);
        exp_q.delete();
        @(negedge clk);
        checkOutput("midreset_done", 32'(done_w[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midreset_no_tick", 32'(done_cnt[0] - dc), 0);
        applyStimulus(0, 8'h3C);
        waitIdle(0, b, h);
        checkOutput("after_reset_len", 32'(b), 160);
        checkOutput("after_reset_done", 32'(done_w[0]), 1);
        repeat (4) @(negedge clk);

        $display("[TB] two stop bits, frame 0x00");
        applyStimulus(1, 8'h00);
        waitIdle(1, b, h);
        checkOutput("stop2_busy_len", 32'(b), 176);
        checkOutput("stop2_high_len", 32'(h), 32);
        checkOutput("stop2_done", 32'(done_w[1]), 1);
        repeat (4) @(negedge clk);

        $display("[TB] 10 clk/bit, frame 0xA5");
        applyStimulus(2, 8'hA5);
        waitIdle(2, b, h);
        checkOutput("div_busy_len", 32'(b), 100);
        checkOutput("div_done", 32'(done_w[2]), 1);
        repeat (10) @(negedge clk);

        checkOutput("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
